// File: rtl/dmem_responder_if.sv
// Request/response bundle between the hart data-memory port and dmem_responder.
// The slave side is the responder; the master side is the hart (or a bench).
interface dmem_responder_if;
    logic [31:0] i_req_addr;
    logic        i_req_ren;
    logic        i_req_wen;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_mask;
    logic        o_req_ready;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    modport slave (
        input  i_req_addr, i_req_ren, i_req_wen, i_req_wdata, i_req_mask, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    modport master (
        output i_req_addr, i_req_ren, i_req_wen, i_req_wdata, i_req_mask, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one byte-masked request at a time, response after LATENCY cycles.
// Define DMEM_RANDOM_STALL_EN to add LFSR-driven request and latency stalls.
//
// state  | meaning
// IDLE   | ready for a request; load/store performed on the accept edge
// WAIT   | latency counter running down, request inputs ignored
// RESP   | response held on the bus until the consumer takes it
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input logic             i_clk,
    input logic             i_rst_n,
    dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic             stall_req;
    logic             stall_cnt;
    logic [32:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             req_err;
    logic [31:0]      lane_bits;
    logic             req_ready;
    logic             accept;
    logic             do_write;

`ifdef DMEM_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall_req = lfsr_q[0];
    assign stall_cnt = lfsr_q[1];
`else
    assign stall_req = 1'b0;
    assign stall_cnt = 1'b0;
`endif

    // 33-bit offset so an address below BASE_ADDR shows up as a borrow
    assign offset    = {1'b0, bus.i_req_addr} - {1'b0, BASE_ADDR};
    assign in_range  = !offset[32] && (offset < SPAN);
    assign idx       = offset[IDX_W+1:2];
    assign req_err   = (bus.i_req_ren & bus.i_req_wen) | (bus.i_req_addr[1:0] != 2'b00)
                     | (bus.i_req_mask == 4'h0) | !in_range;
    assign lane_bits = {{8{bus.i_req_mask[3]}}, {8{bus.i_req_mask[2]}},
                        {8{bus.i_req_mask[1]}}, {8{bus.i_req_mask[0]}}};

    assign req_ready = (state_q == S_IDLE) && !stall_req;
    assign accept    = (bus.i_req_ren | bus.i_req_wen) & req_ready;
    assign do_write  = i_rst_n & accept & bus.i_req_wen & !req_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = LAT_M1;
                    err_d   = req_err;
                    rdata_d = (req_err | bus.i_req_wen) ? 32'h0 : (mem_q[idx] & lane_bits);
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!stall_cnt) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The array is deliberately not reset; stores survive a reset
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.i_req_mask[k]) begin
                    mem_q[idx][8*k +: 8] <= bus.i_req_wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.o_req_ready = req_ready;
    assign bus.o_rsp_valid = (state_q == S_RESP);
    assign bus.o_rsp_rdata = rdata_q;
    assign bus.o_rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases then random traffic vs a word-array model.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned LAT   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [31:0] ref_mem [DEPTH];

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a plain word array addressed by byte address
    function automatic void model(input logic [31:0] a, input logic r, input logic w,
                                  input logic [31:0] wd, input logic [3:0] m,
                                  output logic [31:0] rd, output logic er);
        longint unsigned lo, hi, aa;
        int wi;
        lo = longint'(BASE);
        hi = lo + longint'(DEPTH) * 4;
        aa = longint'(a);
        er = (r && w) || (aa % 4 != 0) || (m == 4'h0) || (aa < lo) || (aa >= hi);
        rd = 32'h0;
        if (!er) begin
            wi = int'((aa - lo) / 4);
            for (int k = 0; k < 4; k++) begin
                if (m[k]) begin
                    if (w) ref_mem[wi][8*k +: 8] = wd[8*k +: 8];
                    else   rd[8*k +: 8] = ref_mem[wi][8*k +: 8];
                end
            end
        end
    endfunction

    task automatic run(input string tag, input logic [31:0] a, input logic r, input logic w,
                       input logic [31:0] wd, input logic [3:0] m, input int hold,
                       output logic [31:0] rd_o);
        logic [31:0] exp_rd, rd;
        logic        exp_er, er;
        int          lat, waited;
        model(a, r, w, wd, m, exp_rd, exp_er);
        bus.i_req_addr  = a;
        bus.i_req_ren   = r;
        bus.i_req_wen   = w;
        bus.i_req_wdata = wd;
        bus.i_req_mask  = m;
        waited = 0;
        while (!bus.o_req_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.o_req_ready) begin
            chk({tag, "_ready_timeout"}, 32'(bus.o_req_ready), 32'h1);
            return;
        end
        @(posedge clk); #1;
        bus.i_req_ren = 1'b0;
        bus.i_req_wen = 1'b0;
        lat = 1;
        while (!bus.o_rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_valid"}, 32'(bus.o_rsp_valid), 32'h1);
`ifdef DMEM_RANDOM_STALL_EN
        chk({tag, "_lat_min"}, 32'(lat >= int'(LAT)), 32'h1);
`else
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
`endif
        rd = bus.o_rsp_rdata;
        er = bus.o_rsp_err;
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 32'(er), 32'(exp_er));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(bus.o_rsp_valid), 32'h1);
            chk({tag, "_hold_rdata"}, bus.o_rsp_rdata, rd);
            chk({tag, "_hold_err"}, 32'(bus.o_rsp_err), 32'(er));
            chk({tag, "_hold_ready"}, 32'(bus.o_req_ready), 32'h0);
        end
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b0;
        chk({tag, "_consumed"}, 32'(bus.o_rsp_valid), 32'h0);
        rd_o = rd;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a, wd;
        logic [3:0]  m;
        int          kind, waited;

        bus.i_req_addr  = 32'h0;
        bus.i_req_ren   = 1'b0;
        bus.i_req_wen   = 1'b0;
        bus.i_req_wdata = 32'h0;
        bus.i_req_mask  = 4'h0;
        bus.i_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("rst_rdata", bus.o_rsp_rdata, 32'h0);
        chk("rst_err", 32'(bus.o_rsp_err), 32'h0);
`ifndef DMEM_RANDOM_STALL_EN
        chk("rst_ready", 32'(bus.o_req_ready), 32'h1);
`endif

        // Store then load-back
        run("t1_st", 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, 0, rd);
        run("t1_ld", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 0, rd);
        chk("t1_ld_const", rd, 32'hDEADBEEF);

        // Byte store and partial-mask load
        run("t2_st", 32'h10, 1'b0, 1'b1, 32'h11000000, 4'b1000, 0, rd);
        run("t2_ld", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 0, rd);
        chk("t2_ld_const", rd, 32'h11ADBEEF);
        run("t2_ldm", 32'h10, 1'b1, 1'b0, 32'h0, 4'b0011, 0, rd);
        chk("t2_ldm_const", rd, 32'h0000BEEF);

        // Errors must not disturb the array, including aliasing targets
        run("t3_w0", BASE, 1'b0, 1'b1, 32'h0BADF00D, 4'hF, 0, rd);
        run("t3_both", 32'h10, 1'b1, 1'b1, 32'h55555555, 4'hF, 0, rd);
        run("t3_mis", 32'h12, 1'b0, 1'b1, 32'h66666666, 4'hF, 0, rd);
        run("t3_mask0", 32'h10, 1'b0, 1'b1, 32'h77777777, 4'h0, 0, rd);
        run("t3_oor", BASE + DEPTH * 4, 1'b0, 1'b1, 32'h88888888, 4'hF, 0, rd);
        run("t3_oor_ld", BASE + DEPTH * 4, 1'b1, 1'b0, 32'h0, 4'hF, 0, rd);
        run("t3_chk10", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 0, rd);
        chk("t3_chk10_const", rd, 32'h11ADBEEF);
        run("t3_chk0", BASE, 1'b1, 1'b0, 32'h0, 4'hF, 0, rd);
        chk("t3_chk0_const", rd, 32'h0BADF00D);
        run("t3_last_st", BASE + DEPTH * 4 - 4, 1'b0, 1'b1, 32'hA5A5_5A5A, 4'hF, 0, rd);
        run("t3_last_ld", BASE + DEPTH * 4 - 4, 1'b1, 1'b0, 32'h0, 4'b0110, 0, rd);
        chk("t3_last_ld_const", rd, 32'h00A5_5A00);

        // Backpressure
        run("t4_bp", 32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 5, rd);
`ifndef DMEM_RANDOM_STALL_EN
        chk("t4_ready_after", 32'(bus.o_req_ready), 32'h1);
`endif

        // Reset during WAIT of an accepted store
        bus.i_req_addr  = 32'h20;
        bus.i_req_wen   = 1'b1;
        bus.i_req_ren   = 1'b0;
        bus.i_req_wdata = 32'hCAFEF00D;
        bus.i_req_mask  = 4'hF;
        waited = 0;
        while (!bus.o_req_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("t5_ready_pre", 32'(bus.o_req_ready), 32'h1);
        @(posedge clk); #1;
        ref_mem[(32'h20 - BASE) / 4] = 32'hCAFEF00D;
        bus.i_req_wen = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t5_valid_rst", 32'(bus.o_rsp_valid), 32'h0);
`ifndef DMEM_RANDOM_STALL_EN
        chk("t5_ready_rst", 32'(bus.o_req_ready), 32'h1);
`endif
        repeat (LAT + 2) @(posedge clk);
        #1 chk("t5_no_rsp", 32'(bus.o_rsp_valid), 32'h0);
        run("t5_ld", 32'h20, 1'b1, 1'b0, 32'h0, 4'hF, 0, rd);
        chk("t5_ld_const", rd, 32'hCAFEF00D);

        // Random traffic over a 16-word window prefilled with known data
        for (int i = 0; i < 16; i++) begin
            run("rnd_fill", BASE + 32'h400 + 32'(i * 4), 1'b0, 1'b1, $urandom, 4'hF, 0, rd);
        end
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 15);
            a    = BASE + 32'h400 + 32'($urandom_range(0, 15) * 4);
            wd   = $urandom;
            m    = 4'($urandom_range(1, 15));
            case (kind)
                0: run("rnd_both", a, 1'b1, 1'b1, wd, m, $urandom_range(0, 2), rd);
                1: run("rnd_mis", a | 32'($urandom_range(1, 3)), 1'b0, 1'b1, wd, m, $urandom_range(0, 2), rd);
                2: run("rnd_mask0", a, 1'b0, 1'b1, wd, 4'h0, $urandom_range(0, 2), rd);
                3: run("rnd_oor", BASE + DEPTH * 4 + 32'h400 + (a & 32'h3C), 1'b0, 1'b1, wd, m,
                       $urandom_range(0, 2), rd);
                4, 5, 6, 7, 8, 9: run("rnd_ld", a, 1'b1, 1'b0, wd, m, $urandom_range(0, 2), rd);
                default: run("rnd_st", a, 1'b0, 1'b1, wd, m, $urandom_range(0, 2), rd);
            endcase
        end
        for (int i = 0; i < 16; i++) begin
            run("rnd_final", BASE + 32'h400 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 4'hF, 0, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
